// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared definitions for the ping-pong stream buffer.
//   BANK_A / BANK_B : encoding of the bank-select bit (write bank, bank_sel)
//   addr_width()    : pointer width for a bank of a given depth (never 0)
// -----------------------------------------------------------------------------
package pingpong_pkg;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   // Pointer width for 'depth' entries; at least one bit so that a
   // depth of 1 or 2 still yields a legal vector.
   function automatic int unsigned addr_width(input int unsigned depth);
      if (depth <= 2) begin
         return 1;
      end
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/pingpong_stream_buffer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// In-domain rate enable for the ping-pong buffer drain side. A counter runs
// 0..TICK_DIV-1 and wraps; 'tick' is high during the last count, so there is
// one tick every TICK_DIV clk cycles (every cycle when TICK_DIV = 1).
// The counter free-runs from reset and ignores the data path entirely.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears the counter
//   tick  : one-cycle enable, combinational from the counter register
// -----------------------------------------------------------------------------
module tick_gen
   import pingpong_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CNT_W = addr_width(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pingpong_stream_buffer.sv
// -----------------------------------------------------------------------------
// pingpong_stream_buffer
// Double buffer between a producer (valid/ready) and a rate-limited consumer.
// The producer fills the write bank while the consumer drains the other bank
// at one word per tick. When the write bank is full and the read bank is
// empty, the banks exchange roles in a single cycle.
//
// Ports:
//   clk       : system clock, all logic on the rising edge
//   reset     : synchronous, active-high; abandons both banks
//   in_valid  : producer offers in_data
//   in_data   : word to store
//   in_ready  : write bank can accept a word
//   y         : registered output word
//   out_tick  : one-cycle pulse, y updated this cycle
//   underrun  : one-cycle pulse, a tick found no readable data
//   swap      : one-cycle pulse, banks exchanged
//   bank_sel  : current write bank (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module pingpong_stream_buffer
   import pingpong_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned TICK_DIV = 50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] y,
   output logic              out_tick,
   output logic              underrun,
   output logic              swap,
   output logic              bank_sel
);

   localparam int unsigned ADDR_W = addr_width(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   // Bank storage; contents are never cleared, only logically discarded.
   logic [DATA_W-1:0] bank_a [DEPTH];
   logic [DATA_W-1:0] bank_b [DEPTH];

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic              wb_q, wb_d;
   logic              wfull_q, wfull_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic              out_tick_q, out_tick_d;
   logic              underrun_q, underrun_d;
   logic              swap_q, swap_d;

   logic              tick;
   logic              wr_en;
   logic              do_swap;
   logic [DATA_W-1:0] rd_data;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign wr_en   = in_valid && !wfull_q;
   // Swap is decided purely on registered state; while wfull_q is set no
   // write can be accepted, and while rvalid_q is clear no read advances,
   // so the swap never competes with either pointer update.
   assign do_swap = wfull_q && !rvalid_q;

   // The read bank is always the one not being written.
   assign rd_data = (wb_q == BANK_A) ? bank_b[rptr_q] : bank_a[rptr_q];

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      wb_d       = wb_q;
      wfull_d    = wfull_q;
      rvalid_d   = rvalid_q;
      y_d        = y_q;
      out_tick_d = 1'b0;
      underrun_d = 1'b0;
      swap_d     = 1'b0;

      if (wr_en) begin
         if (wptr_q == PTR_LAST) begin
            wptr_d  = '0;
            wfull_d = 1'b1;
         end else begin
            wptr_d = wptr_q + ADDR_W'(1);
         end
      end

      if (tick) begin
         if (rvalid_q) begin
            y_d        = rd_data;
            out_tick_d = 1'b1;
            if (rptr_q == PTR_LAST) begin
               rptr_d   = '0;
               rvalid_d = 1'b0;
            end else begin
               rptr_d = rptr_q + ADDR_W'(1);
            end
         end else begin
            // A tick coinciding with a swap still sees the old, empty bank.
            underrun_d = 1'b1;
         end
      end

      if (do_swap) begin
         wb_d     = ~wb_q;
         wfull_d  = 1'b0;
         rvalid_d = 1'b1;
         rptr_d   = '0;
         swap_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         wb_q       <= BANK_A;
         wfull_q    <= 1'b0;
         rvalid_q   <= 1'b0;
         y_q        <= '0;
         out_tick_q <= 1'b0;
         underrun_q <= 1'b0;
         swap_q     <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         wb_q       <= wb_d;
         wfull_q    <= wfull_d;
         rvalid_q   <= rvalid_d;
         y_q        <= y_d;
         out_tick_q <= out_tick_d;
         underrun_q <= underrun_d;
         swap_q     <= swap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         if (wb_q == BANK_A) begin
            bank_a[wptr_q] <= in_data;
         end else begin
            bank_b[wptr_q] <= in_data;
         end
      end
   end

   assign in_ready = !wfull_q;
   assign y        = y_q;
   assign out_tick = out_tick_q;
   assign underrun = underrun_q;
   assign swap     = swap_q;
   assign bank_sel = wb_q;

endmodule

// File: tb/tb_pingpong_stream_buffer.sv
module tb_pingpong_stream_buffer;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: TICK_DIV = 3
   logic              reset;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [DATA_W-1:0] y;
   logic              out_tick;
   logic              underrun;
   logic              swap;
   logic              bank_sel;

   // DUT B: TICK_DIV = 1
   logic              reset_b;
   logic              in_valid_b;
   logic [DATA_W-1:0] in_data_b;
   logic              in_ready_b;
   logic [DATA_W-1:0] y_b;
   logic              out_tick_b;
   logic              underrun_b;
   logic              swap_b;
   logic              bank_sel_b;

   pingpong_stream_buffer #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .TICK_DIV (3)
   ) dut_a (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .y        (y),
      .out_tick (out_tick),
      .underrun (underrun),
      .swap     (swap),
      .bank_sel (bank_sel)
   );

   pingpong_stream_buffer #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .TICK_DIV (1)
   ) dut_b (
      .clk      (clk),
      .reset    (reset_b),
      .in_valid (in_valid_b),
      .in_data  (in_data_b),
      .in_ready (in_ready_b),
      .y        (y_b),
      .out_tick (out_tick_b),
      .underrun (underrun_b),
      .swap     (swap_b),
      .bank_sel (bank_sel_b)
   );

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] sb [$];
   logic [DATA_W-1:0] sb_b [$];
   int cyc = 0;
   int nout = 0;
   int nunder = 0;
   int nswap = 0;
   int under_mid = 0;
   bit last_acc = 1'b0;
   bit ff_seen = 1'b0;

   // One clock of DUT A: record any accepted word in the scoreboard, then
   // sample on the falling edge and match any output against it.
   task automatic step();
      logic [DATA_W-1:0] exp_v;
      last_acc = 1'b0;
      if (reset) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         sb.push_back(in_data);
         last_acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (out_tick) begin
         checks++;
         if (y === 8'hFF) ff_seen = 1'b1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_tick_unexpected: y=%h, required no output", y);
         end else begin
            exp_v = sb.pop_front();
            nout++;
            if (y !== exp_v) begin
               errors++;
               $display("FAIL scoreboard_y: y=%h, required %h", y, exp_v);
            end
         end
      end
      if (underrun) begin
         nunder++;
         if (nout > 0 && sb.size() > 0) under_mid++;
      end
      if (swap) nswap++;
   endtask

   // Run until the scoreboard empties, then expect a trailing underrun.
   task automatic drain(input int exp_n, input string name);
      int u0;
      bit got;
      for (int i = 0; i < 200 && sb.size() > 0; i++) step();
      checks++;
      if (nout !== exp_n) begin
         errors++;
         $display("FAIL %s_count: outputs=%0d, required %0d", name, nout, exp_n);
      end
      u0 = nunder;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (nunder > u0) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_tail_underrun: seen=0, required 1", name);
      end
      checks++;
      if (under_mid !== 0) begin
         errors++;
         $display("FAIL %s_gap_underrun: count=%0d, required 0", name, under_mid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      step();
      step();
      checks++;
      if (y !== 8'h00 || in_ready !== 1'b1 || bank_sel !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: y=%h in_ready=%b bank_sel=%b, required 00 1 0",
                  y, in_ready, bank_sel);
      end
      checks++;
      if (out_tick !== 1'b0 || underrun !== 1'b0 || swap !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: out_tick=%b underrun=%b swap=%b, required 0 0 0",
                  out_tick, underrun, swap);
      end
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (underrun !== ((k % 3) == 0)) begin
            errors++;
            $display("FAIL idle_underrun_c%0d: underrun=%b, required %b", k, underrun,
                     (k % 3) == 0);
         end
         checks++;
         if (out_tick !== 1'b0 || y !== 8'h00) begin
            errors++;
            $display("FAIL idle_output_c%0d: out_tick=%b y=%h, required 0 00", k, out_tick, y);
         end
      end
   endtask

   task automatic test_single_frame();
      nout = 0;
      under_mid = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data = 8'(8'h11 + k);
         step();
         checks++;
         if (!last_acc) begin
            errors++;
            $display("FAIL frame_accept_%0d: accepted=0, required 1", k);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || swap !== 1'b0) begin
         errors++;
         $display("FAIL frame_full: in_ready=%b swap=%b, required 0 0", in_ready, swap);
      end
      step();
      checks++;
      if (swap !== 1'b1 || bank_sel !== 1'b1) begin
         errors++;
         $display("FAIL frame_swap: swap=%b bank_sel=%b, required 1 1", swap, bank_sel);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || swap !== 1'b0) begin
         errors++;
         $display("FAIL frame_ready_after_swap: in_ready=%b swap=%b, required 1 0",
                  in_ready, swap);
      end
      drain(4, "frame");
   endtask

   task automatic test_continuous();
      int k;
      int t24;
      int tswap;
      nout = 0;
      under_mid = 0;
      k = 0;
      t24 = -1;
      tswap = -1;
      for (int i = 0; i < 150 && (k < 8 || sb.size() > 0); i++) begin
         in_valid = (k < 8);
         in_data = 8'(8'h21 + k);
         step();
         if (last_acc) k++;
         if (out_tick && y === 8'h24) begin
            t24 = cyc;
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL cont_ready_at_24: in_ready=%b, required 0", in_ready);
            end
         end
         if (swap && t24 >= 0 && tswap < 0) tswap = cyc;
      end
      in_valid = 1'b0;
      checks++;
      if (k !== 8) begin
         errors++;
         $display("FAIL cont_accepts: accepted=%0d, required 8", k);
      end
      checks++;
      if (t24 < 0 || tswap !== t24 + 1) begin
         errors++;
         $display("FAIL cont_swap_latency: swap_cycle=%0d, required %0d", tswap, t24 + 1);
      end
      drain(8, "cont");
   endtask

   task automatic test_hold_ff();
      int k;
      int held;
      bit hold_done;
      nout = 0;
      under_mid = 0;
      ff_seen = 1'b0;
      k = 0;
      held = 0;
      hold_done = 1'b0;
      for (int i = 0; i < 200 && (k < 8 || sb.size() > 0); i++) begin
         if (k < 8) begin
            in_valid = 1'b1;
            in_data = 8'(8'h41 + k);
         end else if (!hold_done && !in_ready) begin
            in_valid = 1'b1;
            in_data = 8'hFF;
            held++;
         end else begin
            in_valid = 1'b0;
            hold_done = 1'b1;
         end
         step();
         if (last_acc && k < 8) k++;
      end
      in_valid = 1'b0;
      checks++;
      if (held == 0) begin
         errors++;
         $display("FAIL hold_cycles: held=%0d, required >0", held);
      end
      drain(8, "hold");
      checks++;
      if (ff_seen) begin
         errors++;
         $display("FAIL hold_ff_on_y: seen=1, required 0");
      end
   endtask

   task automatic test_reset_mid();
      int u0;
      nout = 0;
      under_mid = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data = 8'(8'h51 + k);
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 40 && nout < 2; i++) step();
      checks++;
      if (nout !== 2) begin
         errors++;
         $display("FAIL rst_mid_prefix: outputs=%0d, required 2", nout);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (y !== 8'h00 || in_ready !== 1'b1 || bank_sel !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: y=%h in_ready=%b bank_sel=%b, required 00 1 0",
                  y, in_ready, bank_sel);
      end
      u0 = nunder;
      nout = 0;
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++;
         if (out_tick !== 1'b0 || y !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_idle_c%0d: out_tick=%b y=%h, required 0 00", k, out_tick, y);
         end
      end
      checks++;
      if (nunder - u0 !== 3) begin
         errors++;
         $display("FAIL rst_mid_underruns: count=%0d, required 3", nunder - u0);
      end
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data = 8'(8'h61 + k);
         step();
      end
      in_valid = 1'b0;
      drain(4, "rst_refill");
   endtask

   task automatic test_tick_div1();
      bit got;
      logic [DATA_W-1:0] exp_v;
      reset_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid_b = 1'b1;
         in_data_b = 8'(8'h31 + k);
         if (in_ready_b) sb_b.push_back(in_data_b);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid_b = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (swap_b) got = 1'b1;
      end
      checks++;
      if (!got || bank_sel_b !== 1'b1) begin
         errors++;
         $display("FAIL div1_swap: seen=%b bank_sel=%b, required 1 1", got, bank_sel_b);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         exp_v = (sb_b.size() > 0) ? sb_b.pop_front() : 8'h00;
         checks++;
         if (out_tick_b !== 1'b1 || y_b !== exp_v) begin
            errors++;
            $display("FAIL div1_out_%0d: out_tick=%b y=%h, required 1 %h", k, out_tick_b,
                     y_b, exp_v);
         end
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (underrun_b !== 1'b1 || out_tick_b !== 1'b0) begin
         errors++;
         $display("FAIL div1_tail: underrun=%b out_tick=%b, required 1 0", underrun_b,
                  out_tick_b);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      reset_b = 1'b1;
      in_valid_b = 1'b0;
      in_data_b = '0;
      test_reset();
      test_single_frame();
      test_continuous();
      test_hold_ff();
      test_reset_mid();
      test_tick_div1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
